// File: rtl/uop_decoder.sv
// uop_decoder: op/funct/rd -> registered control word; op 111 expands into a BURST_LEN micro-op burst.
// 1-cycle latency; stall freezes outputs/state, flush drops everything, in_ready low while a burst is in flight.
module uop_decoder #(
  parameter int OP_W      = 3,
  parameter int FUNCT_W   = 6,
  parameter int RD_W      = 5,
  parameter int PC_REG    = 15,
  parameter int BURST_LEN = 9,
  parameter int MEMC_W    = 7,
  localparam int IDX_W    = $clog2(BURST_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [RD_W-1:0]    rd,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [1:0]         reg_src,
  output logic [1:0]         imm_src,
  output logic               alu_src,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               mem_write,
  output logic               branch,
  output logic               pc_src,
  output logic [3:0]         alu_control,
  output logic [1:0]         flag_write,
  output logic [MEMC_W-1:0]  mem_ctrl,
  output logic [RD_W-1:0]    rd_out,
  output logic [IDX_W-1:0]   uop_idx,
  output logic               illegal
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  typedef struct packed {
    logic [1:0]        reg_src;
    logic [1:0]        imm_src;
    logic              alu_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_write;
    logic              branch;
    logic [3:0]        alu_control;
    logic [1:0]        flag_write;
    logic [MEMC_W-1:0] mem_ctrl;
    logic              illegal;
  } ctrl_t;

  logic [0:0]        state;
  ctrl_t             ctrl_q;
  ctrl_t             dec;
  logic [9:0]        cv;
  logic [MEMC_W-1:0] mc;
  logic              bad_op;
  logic              bad_alu;
  logic              is_burst;
  logic              f0;
  logic              dec_burst;
  logic              dec_pc_src;
  logic              burst_last;
  logic              accept;
  logic [RD_W-1:0]   rd_next;
  logic              burst_pc_src;

  // cv = {reg_src, imm_src, alu_src, mem_to_reg, reg_write, mem_write, branch, aluop}
  always_comb begin
    cv       = '0;
    mc       = '0;
    bad_op   = 1'b0;
    is_burst = 1'b0;
    if (op > OP_W'(7)) begin
      bad_op = 1'b1;
    end else begin
      case (op[2:0])
        3'b000: cv = funct[5] ? 10'b00_00_1_0_1_0_0_1 : 10'b00_00_0_0_1_0_0_1;
        3'b001: cv = funct[0] ? 10'b00_01_1_1_1_0_0_0 : 10'b10_01_1_1_0_1_0_0;
        3'b010: cv = 10'b01_10_1_0_0_0_1_0;
        3'b100: begin
          cv = 10'b00_00_0_1_1_0_0_1;
          mc = funct[0] ? MEMC_W'(7'b1101010) : MEMC_W'(7'b1100010);
        end
        3'b101: begin
          cv = 10'b00_00_1_0_0_1_0_1;
          mc = MEMC_W'(7'b0000001);
        end
        3'b110: begin
          cv = 10'b00_00_0_1_1_0_0_1;
          mc = MEMC_W'(7'b1101110);
        end
        3'b111: begin
          // burst micro-ops reuse the image-load decode with funct[0] forced low
          cv       = 10'b00_00_0_1_1_0_0_1;
          mc       = MEMC_W'(7'b1100010);
          is_burst = 1'b1;
        end
        default: bad_op = 1'b1;
      endcase
    end
  end

  always_comb begin
    f0      = funct[0] & ~is_burst;
    bad_alu = 1'b0;
    dec     = '0;
    dec.alu_control = 4'b0011;
    if (cv[0]) begin
      case (funct[4:1])
        4'b0000: dec.alu_control = 4'b0000;
        4'b0001: dec.alu_control = 4'b0110;
        4'b0010: dec.alu_control = 4'b0010;
        4'b0011: dec.alu_control = 4'b0111;
        4'b0100: dec.alu_control = 4'b0011;
        4'b1100: dec.alu_control = 4'b0101;
        4'b1101: dec.alu_control = 4'b0001;
        4'b1111: dec.alu_control = 4'b0100;
        default: begin
          dec.alu_control = 4'b0000;
          bad_alu         = 1'b1;
        end
      endcase
      dec.flag_write = {f0, f0 & ((dec.alu_control == 4'b0011) || (dec.alu_control == 4'b0010))};
    end
    dec.reg_src    = cv[9:8];
    dec.imm_src    = cv[7:6];
    dec.alu_src    = cv[5];
    dec.mem_to_reg = cv[4];
    dec.reg_write  = cv[3];
    dec.mem_write  = cv[2];
    dec.branch     = cv[1];
    dec.mem_ctrl   = mc;
    if (bad_op || bad_alu) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign dec_burst    = is_burst & ~bad_alu & ~bad_op;
  assign dec_pc_src   = ((rd == RD_W'(PC_REG)) && dec.reg_write) || dec.branch;
  assign burst_last   = (uop_idx == IDX_W'(BURST_LEN - 1));
  assign in_ready     = ~stall & ~flush & ((state == IDLE) || burst_last);
  assign accept       = in_valid & in_ready;
  assign rd_next      = rd_out + RD_W'(1);
  assign burst_pc_src = ((rd_next == RD_W'(PC_REG)) && ctrl_q.reg_write) || ctrl_q.branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctrl_q    <= '0;
      out_valid <= 1'b0;
      rd_out    <= '0;
      uop_idx   <= '0;
      pc_src    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      uop_idx   <= '0;
    end else if (!stall) begin
      if (accept) begin
        state     <= dec_burst ? BURST : IDLE;
        ctrl_q    <= dec;
        out_valid <= 1'b1;
        rd_out    <= rd;
        uop_idx   <= '0;
        pc_src    <= dec_pc_src;
      end else if (state == BURST && !burst_last) begin
        uop_idx <= uop_idx + IDX_W'(1);
        rd_out  <= rd_next;
        pc_src  <= burst_pc_src;
      end else begin
        // idle with nothing accepted: drop valid, keep the last control word visible
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

  assign reg_src     = ctrl_q.reg_src;
  assign imm_src     = ctrl_q.imm_src;
  assign alu_src     = ctrl_q.alu_src;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign mem_write   = ctrl_q.mem_write;
  assign branch      = ctrl_q.branch;
  assign alu_control = ctrl_q.alu_control;
  assign flag_write  = ctrl_q.flag_write;
  assign mem_ctrl    = ctrl_q.mem_ctrl;
  assign illegal     = ctrl_q.illegal;

endmodule
